comp_seq: RTL and testbench

//   Multi-cycle, parametrised magnitude comparator for the MultDiv unit.

---
 rtl/comp_seq.sv | 118 +++++++++++
 tb/tb_comp_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/comp_seq.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per clock, signed/unsigned per op.
// Optional feature: define EARLY_EXIT_EN to finish as soon as the first differing digit is seen.
module comp_seq #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
   output logic             EQ,
   output logic             GT,
   output logic             LT
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_eq;
   logic             r_gt;

   logic [WIDTH-1:0] w_sign_mask;
   logic [DIGIT-1:0] w_digit_a;
   logic [DIGIT-1:0] w_digit_b;
   logic             w_differ;
   logic             w_eq_next;
   logic             w_gt_next;
   logic             w_cnt_zero;
   logic             w_last;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign w_sign_mask = {is_signed, {(WIDTH-1){1'b0}}};

   assign w_digit_a  = r_a[WIDTH-1 -: DIGIT];
   assign w_digit_b  = r_b[WIDTH-1 -: DIGIT];
   assign w_differ   = (w_digit_a != w_digit_b);
   assign w_eq_next  = r_eq & ~w_differ;
   assign w_gt_next  = (r_eq & w_differ) ? (w_digit_a > w_digit_b) : r_gt;
   assign w_cnt_zero = (r_cnt == '0);

`ifdef EARLY_EXIT_EN
   assign w_last = w_cnt_zero | (r_eq & w_differ);
`else
   assign w_last = w_cnt_zero;
`endif

   // Once a digit differs, the first difference decides the order; later digits are ignored.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_eq    <= 1'b1;
         r_gt    <= 1'b0;
         ready   <= 1'b1;
         done    <= 1'b0;
         EQ      <= 1'b0;
         GT      <= 1'b0;
         LT      <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= A ^ w_sign_mask;
                  r_b     <= B ^ w_sign_mask;
                  r_eq    <= 1'b1;
                  r_gt    <= 1'b0;
                  r_cnt   <= CW'(STEPS - 1);
                  ready   <= 1'b0;
                  EQ      <= 1'b0;
                  GT      <= 1'b0;
                  LT      <= 1'b0;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_a   <= r_a << DIGIT;
               r_b   <= r_b << DIGIT;
               r_eq  <= w_eq_next;
               r_gt  <= w_gt_next;
               r_cnt <= r_cnt - CW'(1);
               if (w_last) begin
                  ready   <= 1'b1;
                  done    <= 1'b1;
                  EQ      <= w_eq_next;
                  GT      <= w_gt_next & ~w_eq_next;
                  LT      <= ~w_gt_next & ~w_eq_next;
                  r_state <= DONE;
               end
            end
            default: begin
               ready   <= 1'b1;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comp_seq.sv
// Directed and sweep bench for comp_seq: 8-bit/2-bit instance plus 32-bit instances at DIGIT 1, 2, 4.
module tb_comp_seq;

`ifdef EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset_n;
   logic       start;
   logic       is_signed;
   logic [7:0] A;
   logic [7:0] B;
   logic       ready, done, EQ, GT, LT;

   logic [31:0] rA, rB;
   logic        rS, rStart;
   logic        rdy1, dn1, eq1, gt1, lt1;
   logic        rdy2, dn2, eq2, gt2, lt2;
   logic        rdy4, dn4, eq4, gt4, lt4;

   int errors = 0;
   int checks = 0;

   comp_seq #(.WIDTH(8), .DIGIT(2)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
      .A(A), .B(B), .ready(ready), .done(done), .EQ(EQ), .GT(GT), .LT(LT));

   comp_seq #(.WIDTH(32), .DIGIT(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .start(rStart), .is_signed(rS),
      .A(rA), .B(rB), .ready(rdy1), .done(dn1), .EQ(eq1), .GT(gt1), .LT(lt1));

   comp_seq #(.WIDTH(32), .DIGIT(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .start(rStart), .is_signed(rS),
      .A(rA), .B(rB), .ready(rdy2), .done(dn2), .EQ(eq2), .GT(gt2), .LT(lt2));

   comp_seq #(.WIDTH(32), .DIGIT(4)) dut4 (
      .clock(clock), .reset_n(reset_n), .start(rStart), .is_signed(rS),
      .A(rA), .B(rB), .ready(rdy4), .done(dn4), .EQ(eq4), .GT(gt4), .LT(lt4));

   // Latency in negedges from the start negedge; early is the step of the first differing digit plus one.
   function automatic int expLat(input int early);
      return EARLY ? early : 5;
   endfunction

   // Drives one 8-bit operation and waits (bounded) for done; lat=-1 on timeout.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s,
                                output int lat, output logic [2:0] flags);
      @(negedge clock);
      A = a; B = b; is_signed = s; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      flags = {EQ, GT, LT};
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
      rStart = 1'b0; rS = 1'b0; rA = '0; rB = '0;
      #12;
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if ({EQ, GT, LT} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {EQ, GT, LT}); end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle: got ready=%b done=%b expected 1/0", ready, done); end
   endtask

   task automatic test_compare();
      int lat;
      logic [2:0] f;
      applyStimulus(8'hA5, 8'hA5, 1'b0, lat, f);
      checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL eq_latency: got %0d expected 5", lat); end
      checks++; if (f !== 3'b100) begin errors++; $display("[TB] FAIL eq_flags: got %b expected 100", f); end
      applyStimulus(8'h80, 8'h7F, 1'b0, lat, f);
      checks++; if (f !== 3'b010) begin errors++; $display("[TB] FAIL unsigned_80_7f: got %b expected 010", f); end
      checks++; if (lat !== expLat(2)) begin errors++; $display("[TB] FAIL unsigned_80_7f_lat: got %0d expected %0d", lat, expLat(2)); end
      applyStimulus(8'h80, 8'h7F, 1'b1, lat, f);
      checks++; if (f !== 3'b001) begin errors++; $display("[TB] FAIL signed_80_7f: got %b expected 001", f); end
      applyStimulus(8'hFF, 8'hFE, 1'b1, lat, f);
      checks++; if (f !== 3'b010) begin errors++; $display("[TB] FAIL signed_ff_fe: got %b expected 010", f); end
      checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL signed_ff_fe_lat: got %0d expected 5", lat); end
      applyStimulus(8'h00, 8'hFF, 1'b1, lat, f);
      checks++; if (f !== 3'b010) begin errors++; $display("[TB] FAIL signed_00_ff: got %b expected 010", f); end
      applyStimulus(8'h00, 8'hFF, 1'b0, lat, f);
      checks++; if (f !== 3'b001) begin errors++; $display("[TB] FAIL unsigned_00_ff: got %b expected 001", f); end
   endtask

   task automatic test_early_exit();
      int lat;
      logic [2:0] f;
      applyStimulus(8'h40, 8'h00, 1'b0, lat, f);
      checks++; if (lat !== expLat(2)) begin errors++; $display("[TB] FAIL early_exit_lat: got %0d expected %0d", lat, expLat(2)); end
      checks++; if (f !== 3'b010) begin errors++; $display("[TB] FAIL early_exit_flags: got %b expected 010", f); end
   endtask

   task automatic test_ignore_start();
      int lat;
      @(negedge clock);
      A = 8'h12; B = 8'h34; is_signed = 1'b0; start = 1'b1;
      @(negedge clock);
      checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL run_ready: got %b expected 0", ready); end
      A = 8'hFF; B = 8'h00; start = 1'b1;
      @(negedge clock);
      start = 1'b0; A = 8'h00; B = 8'hFF;
      checks++; if ({EQ, GT, LT} !== 3'b000) begin errors++; $display("[TB] FAIL run_flags_clear: got %b expected 000", {EQ, GT, LT}); end
      lat = 2;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      checks++; if (lat !== expLat(3)) begin errors++; $display("[TB] FAIL ignore_lat: got %0d expected %0d", lat, expLat(3)); end
      checks++; if ({EQ, GT, LT} !== 3'b001) begin errors++; $display("[TB] FAIL ignore_flags: got %b expected 001", {EQ, GT, LT}); end
      @(negedge clock);
      checks++; if ({EQ, GT, LT} !== 3'b001 || done !== 1'b0) begin errors++; $display("[TB] FAIL flags_hold: got flags=%b done=%b expected 001/0", {EQ, GT, LT}, done); end
   endtask

   task automatic test_abort();
      int lat;
      logic [2:0] f;
      @(negedge clock);
      A = 8'h01; B = 8'h01; is_signed = 1'b0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL abort_ctrl: got ready=%b done=%b expected 1/0", ready, done); end
      checks++; if ({EQ, GT, LT} !== 3'b000) begin errors++; $display("[TB] FAIL abort_flags: got %b expected 000", {EQ, GT, LT}); end
      @(negedge clock);
      reset_n = 1'b1;
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (done === 1'b1) lat++;
      end
      checks++; if (lat !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", lat); end
      applyStimulus(8'h01, 8'h02, 1'b0, lat, f);
      checks++; if (f !== 3'b001) begin errors++; $display("[TB] FAIL after_abort: got %b expected 001", f); end
      checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL after_abort_lat: got %0d expected 5", lat); end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clock);
      A = 8'h10; B = 8'h20; is_signed = 1'b0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_timeout: got done=%b expected 1", done); end
      checks++; if ({EQ, GT, LT} !== 3'b001) begin errors++; $display("[TB] FAIL b2b_first: got %b expected 001", {EQ, GT, LT}); end
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready: got %b expected 1", ready); end
      A = 8'hC3; B = 8'h3C; is_signed = 1'b1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      checks++; if ({EQ, GT, LT} !== 3'b001) begin errors++; $display("[TB] FAIL b2b_second: got %b expected 001", {EQ, GT, LT}); end
      checks++; if (lat !== expLat(2)) begin errors++; $display("[TB] FAIL b2b_second_lat: got %0d expected %0d", lat, expLat(2)); end
   endtask

   task automatic test_random_sweep();
      logic [31:0] a, b;
      logic        s;
      logic [2:0]  exp;
      logic [2:0]  got [3];
      logic        seen [3];
      int          cyc;
      for (int it = 0; it < 24; it++) begin
         a = $urandom;
         b = $urandom;
         s = it[0];
         if (it % 4 == 1) b = a;
         else if (it % 4 == 2) b = {a[31:6], b[5:0]};
         else if (it == 3) begin a = 32'h8000_0000; b = 32'h7FFF_FFFF; end
         if (a == b) exp = 3'b100;
         else if (s ? ($signed(a) > $signed(b)) : (a > b)) exp = 3'b010;
         else exp = 3'b001;
         @(negedge clock);
         rA = a; rB = b; rS = s; rStart = 1'b1;
         @(negedge clock);
         rStart = 1'b0;
         for (int k = 0; k < 3; k++) begin seen[k] = 1'b0; got[k] = 3'b000; end
         cyc = 0;
         while (!(seen[0] && seen[1] && seen[2]) && cyc < 40) begin
            if (dn1 === 1'b1) begin seen[0] = 1'b1; got[0] = {eq1, gt1, lt1}; end
            if (dn2 === 1'b1) begin seen[1] = 1'b1; got[1] = {eq2, gt2, lt2}; end
            if (dn4 === 1'b1) begin seen[2] = 1'b1; got[2] = {eq4, gt4, lt4}; end
            @(negedge clock);
            cyc++;
         end
         for (int k = 0; k < 3; k++) begin
            checks++; if (seen[k] !== 1'b1) begin errors++; $display("[TB] FAIL sweep_timeout it=%0d dut=%0d: got no done expected done", it, k); end
            checks++; if (got[k] !== exp) begin errors++; $display("[TB] FAIL sweep_flags it=%0d dut=%0d a=%h b=%h s=%b: got %b expected %b", it, k, a, b, s, got[k], exp); end
            checks++; if (!$onehot(got[k])) begin errors++; $display("[TB] FAIL sweep_onehot it=%0d dut=%0d: got %b expected one flag", it, k, got[k]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_compare();
      test_early_exit();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      test_random_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
